// File: rtl/micro_inst_serializer_if.sv
// Field-input and byte-output bus of the micro-instruction serializer.
`timescale 1ns/1ps
interface micro_inst_serializer_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_type;
  logic [4:0]  in_src;
  logic [4:0]  in_dst;
  logic [10:0] in_imm;
  logic [9:0]  in_branch;
  logic        in_alu_en;
  logic [3:0]  in_alu_op;
  logic        in_rf_en;
  logic        in_rf_rw;
  logic        in_mem_en;
  logic        in_mem_rw;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        out_last;
  logic        err;

  // Environment side: supplies fields, consumes bytes.
  modport master (
    output in_valid, in_type, in_src, in_dst, in_imm, in_branch,
           in_alu_en, in_alu_op, in_rf_en, in_rf_rw, in_mem_en, in_mem_rw, out_ready,
    input  in_ready, out_valid, out_byte, out_last, err
  );

  // Serializer side.
  modport slave (
    input  in_valid, in_type, in_src, in_dst, in_imm, in_branch,
           in_alu_en, in_alu_op, in_rf_en, in_rf_rw, in_mem_en, in_mem_rw, out_ready,
    output in_ready, out_valid, out_byte, out_last, err
  );
endinterface

// File: rtl/micro_inst_serializer.sv
// Packs micro-instruction fields into a 44-bit word and streams it out LSB byte first.
`timescale 1ns/1ps
module micro_inst_serializer #(
  parameter int unsigned ALU_OP_MAX = 9,
  parameter int unsigned BEATS      = 6
) (
  input logic                    clk,
  input logic                    rst_n,
  micro_inst_serializer_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  localparam logic [3:0] AluOpMax = 4'(ALU_OP_MAX);
  localparam logic [2:0] LastBeat = 3'(BEATS - 1);

  state_e      state_q, state_d;
  logic [2:0]  beat_q, beat_d;
  logic [43:0] word_q, word_d;
  logic        err_q, err_d;

  logic [9:0]  args;
  logic [43:0] packed_word;
  logic [47:0] word_ext;
  logic        legal, last_beat, in_fire, out_fire;

  // Field packing; alu_op is masked when the ALU is not enabled.
  always_comb begin
    args        = {1'b0, bus.in_mem_rw, bus.in_mem_en, bus.in_rf_rw, bus.in_rf_en,
                   bus.in_alu_en ? bus.in_alu_op : 4'd0, bus.in_alu_en};
    packed_word = {bus.in_type, bus.in_src, bus.in_dst, bus.in_imm, bus.in_branch, args};
    legal       = !(bus.in_alu_en && (bus.in_alu_op > AluOpMax));
  end

  // Handshake and output decode; in_ready is forced low while reset is held.
  always_comb begin
    last_beat     = (state_q == StSend) && (beat_q == LastBeat);
    word_ext      = {4'b0000, word_q};
    bus.out_valid = (state_q == StSend);
    bus.out_last  = last_beat;
    bus.out_byte  = word_ext[{beat_q, 3'b000} +: 8];
    bus.err       = err_q;
    bus.in_ready  = rst_n && ((state_q == StIdle) || (last_beat && bus.out_ready));
    in_fire       = bus.in_valid && bus.in_ready;
    out_fire      = bus.out_valid && bus.out_ready;
  end

  // Next-state logic: capture legal words, drop illegal ones with an err pulse.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    word_d  = word_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_fire) begin
          if (legal) begin
            state_d = StSend;
            beat_d  = 3'd0;
            word_d  = packed_word;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StSend: begin
        if (out_fire) begin
          if (beat_q == LastBeat) begin
            beat_d = 3'd0;
            // A legal word arriving with the final handshake restarts with no gap.
            if (in_fire && legal) begin
              word_d = packed_word;
            end else begin
              state_d = StIdle;
              err_d   = in_fire;
            end
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      beat_q  <= 3'd0;
      word_q  <= 44'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_micro_inst_serializer.sv
// Directed self-checking bench for micro_inst_serializer.
`timescale 1ns/1ps
module tb_micro_inst_serializer;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  micro_inst_serializer_if bus ();

  micro_inst_serializer #(
    .ALU_OP_MAX(9),
    .BEATS     (6)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Expected byte streams: word A = 0x23380500063, word B = 0x00000000180.
  logic [7:0] exp_a [6] = '{8'h63, 8'h00, 8'h50, 8'h80, 8'h33, 8'h02};
  logic [7:0] exp_b [6] = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic set_fields(input logic [2:0] t, input logic [4:0] s, input logic [4:0] d,
                            input logic [10:0] imm, input logic [9:0] br, input logic ae,
                            input logic [3:0] op, input logic rfe, input logic rfw,
                            input logic me, input logic mw);
    bus.in_type   = t;
    bus.in_src    = s;
    bus.in_dst    = d;
    bus.in_imm    = imm;
    bus.in_branch = br;
    bus.in_alu_en = ae;
    bus.in_alu_op = op;
    bus.in_rf_en  = rfe;
    bus.in_rf_rw  = rfw;
    bus.in_mem_en = me;
    bus.in_mem_rw = mw;
  endtask

  task automatic set_word_a();
    set_fields(3'd1, 5'd3, 5'd7, 11'h005, 10'd0, 1'b1, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic set_word_b();
    set_fields(3'd0, 5'd0, 5'd0, 11'h000, 10'd0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_word_a();
    #3;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
    end
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b last=%b err=%b expected all 0",
               bus.out_valid, bus.out_last, bus.err);
    end
    n_checks++;
    if (bus.out_byte !== 8'h00) begin
      n_fail++; $display("FAIL reset_byte: got %h expected 00", bus.out_byte);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1,0",
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_basic();
    @(negedge clk);
    set_word_a();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    // Fields outside a transfer must be ignored.
    set_fields(3'd7, 5'd31, 5'd31, 11'h7ff, 10'h3ff, 1'b1, 4'd9, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_byte !== exp_a[i] ||
          bus.out_last !== (i == 5) || bus.in_ready !== (i == 5)) begin
        n_fail++;
        $display("FAIL basic_beat%0d: valid=%b byte=%h last=%b in_ready=%b expected 1,%h,%b,%b",
                 i, bus.out_valid, bus.out_byte, bus.out_last, bus.in_ready,
                 exp_a[i], (i == 5), (i == 5));
      end
      @(negedge clk);
    end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_done: out_valid=%b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_stall();
    int hs;
    set_word_a();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    hs = 0;
    for (int c = 0; c < 40 && hs < 6; c++) begin
      bus.out_ready = (c % 3 == 0);
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_byte !== exp_a[hs] || bus.out_last !== (hs == 5) ||
          bus.in_ready !== (hs == 5 && bus.out_ready)) begin
        n_fail++;
        $display("FAIL stall_cycle%0d: valid=%b byte=%h last=%b in_ready=%b expected 1,%h,%b,%b",
                 c, bus.out_valid, bus.out_byte, bus.out_last, bus.in_ready, exp_a[hs],
                 (hs == 5), (hs == 5 && bus.out_ready));
      end
      if (bus.out_valid && bus.out_ready) hs++;
      @(negedge clk);
    end
    n_checks++;
    if (hs != 6 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_handshakes: count=%0d out_valid=%b expected 6,0", hs, bus.out_valid);
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_illegal();
    set_fields(3'd2, 5'd1, 5'd2, 11'h010, 10'h001, 1'b1, 4'd12, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    #1;
    n_checks++;
    if (bus.err !== 1'b0) begin
      n_fail++; $display("FAIL illegal_pre_err: got %b expected 0", bus.err);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.err !== 1'b1 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_pulse: err=%b valid=%b in_ready=%b expected 1,0,1",
               bus.err, bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    n_checks++;
    if (bus.err !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_after: err=%b valid=%b in_ready=%b expected 0,0,1",
               bus.err, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_alu_masked();
    set_word_b();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_byte !== exp_b[i] || bus.out_last !== (i == 5)) begin
        n_fail++;
        $display("FAIL masked_beat%0d: valid=%b byte=%h last=%b expected 1,%h,%b",
                 i, bus.out_valid, bus.out_byte, bus.out_last, exp_b[i], (i == 5));
      end
      @(negedge clk);
    end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL masked_done: out_valid=%b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_byte;
    set_word_a();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      if (i == 5) begin
        set_word_b();
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      exp_byte = (i < 6) ? exp_a[i] : exp_b[i - 6];
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_byte !== exp_byte ||
          bus.out_last !== (i % 6 == 5) || bus.in_ready !== (i % 6 == 5) || bus.err !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_beat%0d: valid=%b byte=%h last=%b in_ready=%b err=%b expected 1,%h,%b,%b,0",
                 i, bus.out_valid, bus.out_byte, bus.out_last, bus.in_ready, bus.err,
                 exp_byte, (i % 6 == 5), (i % 6 == 5));
      end
      @(negedge clk);
    end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_done: out_valid=%b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_mid_reset();
    set_word_a();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_byte !== 8'h80) begin
      n_fail++;
      $display("FAIL midrst_beat3: valid=%b byte=%h expected 1,80", bus.out_valid, bus.out_byte);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_byte !== 8'h00) begin
      n_fail++;
      $display("FAIL midrst_async: valid=%b in_ready=%b byte=%h expected 0,0,00",
               bus.out_valid, bus.in_ready, bus.out_byte);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_release: in_ready=%b valid=%b expected 1,0",
               bus.in_ready, bus.out_valid);
    end
    @(negedge clk);
    set_word_b();
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_byte !== 8'h80 || bus.out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_restart: valid=%b byte=%h last=%b expected 1,80,0",
               bus.out_valid, bus.out_byte, bus.out_last);
    end
    repeat (6) @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_done: out_valid=%b expected 0", bus.out_valid);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_stall();
    test_illegal();
    test_alu_masked();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/micro_inst_serializer.md
MICRO_INST_SERIALIZER -- requirements
Module: micro_inst_serializer

Interface
REQ-001 Parameter ALU_OP_MAX, default 9: the highest legal alu_op code (9 = cmp).
REQ-002 Parameter BEATS, default 6: bytes per 44-bit word (fixed; other values are unsupported).
REQ-003 Port clk  in  1: the single clock; all state updates on the rising edge.
REQ-004 Port rst_n  in  1: reset, asynchronous and active-low.
REQ-005 Port in_valid / in_ready  in / out  1 each: field-input handshake; a transfer occurs when both are high at a rising edge.
REQ-006 Port in_type  in  3: micro-instruction type.
REQ-007 Port in_src / in_dst  in  5 each: source and destination register indices.
REQ-008 Port in_imm  in  11: immediate value.
REQ-009 Port in_branch  in  10: branch target.
REQ-010 Port in_alu_en  in  1; in_alu_op  in  4; in_rf_en, in_rf_rw, in_mem_en, in_mem_rw  in  1 each: control flags.
REQ-011 Port out_valid / out_ready  out / in  1 each: byte-output handshake.
REQ-012 Port out_byte  out  8: current beat of the packed word.
REQ-013 Port out_last  out  1: high on beat BEATS-1 only.
REQ-014 Port err  out  1: one-cycle pulse when an input word is rejected.

Function
REQ-015 The packed word SHALL be 44 bits: [43:41] type, [40:36] src, [35:31] dst, [30:20] imm, [19:10] branch, [9:0] args.
REQ-016 The args field SHALL be: [0] alu_en, [4:1] alu_op, [5] rf_en, [6] rf_rw, [7] mem_en, [8] mem_rw, [9] = 0.
REQ-017 When alu_en = 0, args[4:1] SHALL be forced to 0 regardless of in_alu_op.
REQ-018 An input with alu_en = 1 and alu_op > ALU_OP_MAX SHALL be accepted but dropped: err pulses in the following cycle, no bytes are emitted, and the state stays or becomes IDLE.
REQ-019 The block SHALL have two states, IDLE and SEND, plus a 3-bit beat counter (0..5).
REQ-020 In IDLE: in_ready = 1 and out_valid = 0; a legal transfer captures the packed word into a 44-bit register and moves to SEND with beat = 0.
REQ-021 In SEND: out_valid = 1, and out_byte = word[8*beat+7 : 8*beat] (LSB byte first); beat 5 SHALL carry {4'b0, word[43:40]}.
REQ-022 out_byte, out_last and the beat SHALL hold stable while out_valid = 1 and out_ready = 0.
REQ-023 Each out_valid & out_ready SHALL advance beat by 1; acceptance of beat 5 ends the word.
REQ-024 in_ready SHALL be 1 in IDLE, or in SEND when beat = 5 and out_ready = 1; in all other cases it is 0.
REQ-025 A legal transfer coincident with the beat-5 handshake SHALL load the new word and restart at beat 0 in SEND, giving back-to-back throughput of one byte per cycle with no gap.
REQ-026 An illegal transfer coincident with the beat-5 handshake SHALL go to IDLE with err pulsed.
REQ-027 Latency SHALL be one cycle from the input transfer edge to out_valid = 1 with beat 0.
REQ-028 in_* fields SHALL be sampled only on a transfer; values outside transfers are ignored.

Reset
REQ-029 On rst_n low, asynchronously: state = IDLE, beat = 0, word register = 0, out_valid = 0, out_last = 0, out_byte = 0, err = 0; in_ready SHALL be 0 while rst_n is low.
REQ-030 A reset asserted in mid-word SHALL discard the word; after release, the first in_valid is accepted in IDLE.

Verification
REQ-031 Fields type=1, src=3, dst=7, imm=0x005, branch=0, alu_en=1, op=1, rf_en=1, rf_rw=1, out_ready held 1 -> bytes 0x63,0x00,0x50,0x80,0x33,0x02 on 6 consecutive cycles, out_last on 0x02 only (word 0x23380500063).
REQ-032 The same word with out_ready toggled 1,0,0,1,... -> each byte holds stable through the stalls; exactly 6 handshakes occur; in_ready = 0 until beat 5 is accepted.
REQ-033 alu_en=1, op=12 -> err = 1 for exactly one cycle, out_valid never rises, in_ready stays 1.
REQ-034 alu_en=0, op=5, mem_en=1, mem_rw=1, all other fields 0 -> args = 0x180, bytes 0x80,0x01,0x00,0x00,0x00,0x00.
REQ-035 Two words presented back-to-back with out_ready = 1 -> 12 consecutive valid bytes with no idle cycle and out_last at beats 5 and 11.
REQ-036 rst_n pulsed low at beat 3 -> out_valid drops immediately; after release in_ready = 1 and the next word starts at beat 0.
